// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg -- shared definitions for the UART transmit controller.
//   tx_state_e : frame sequencing states (IDLE, START, DATA, PARITY, STOP)
//   MUX_*      : line-source select encodings driven on mux_sel
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] MUX_START  = 2'b00;
  localparam logic [1:0] MUX_DATA   = 2'b01;
  localparam logic [1:0] MUX_PARITY = 2'b10;
  localparam logic [1:0] MUX_STOP   = 2'b11;

endpackage

// File: rtl/uart_tx_parity.sv
// uart_tx_parity -- parity generator for the UART transmit controller.
//   data    : latched payload (DATA_WIDTH bits)
//   par_typ : 0 = even parity, 1 = odd parity
//   par_bit : XOR-reduction of data, inverted for odd parity
module uart_tx_parity #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl -- UART transmit frame controller (start, data LSB first,
// optional parity, stop). One frame bit per clk cycle.
//   clk        : bit-rate clock, rising edge
//   rst        : asynchronous active-low reset
//   p_data     : parallel payload, latched when a frame is accepted
//   data_valid : payload offered; accepted in IDLE or STOP
//   par_en     : append a parity bit (latched per frame)
//   par_typ    : 0 even, 1 odd parity (latched per frame)
//   mux_sel    : line-source select (00 start, 01 data, 10 parity, 11 stop/idle)
//   ser_data   : current payload bit
//   par_bit    : parity of the latched frame
//   busy       : frame in progress
// Build option: define UART_TX_PARITY_EN to include the PARITY state and
// parity generator; otherwise par_en/par_typ are ignored and par_bit is 0.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  tx_state_e             state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CW-1:0]         count_q;
  logic                  frame_load;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_typ_q;
`else
  logic unused_par_inputs;
  assign unused_par_inputs = par_en ^ par_typ;
`endif

  // A new frame can be accepted from IDLE or from STOP (back-to-back).
  assign frame_load = data_valid && ((state_q == ST_IDLE) || (state_q == ST_STOP));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      count_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
`endif
    end else begin
      if (frame_load) begin
        data_q    <= p_data;
`ifdef UART_TX_PARITY_EN
        par_en_q  <= par_en;
        par_typ_q <= par_typ;
`endif
      end

      case (state_q)
        ST_IDLE: begin
          if (data_valid) state_q <= ST_START;
        end
        ST_START: begin
          state_q <= ST_DATA;
          count_q <= '0;
        end
        ST_DATA: begin
          // Counter holds at the last bit; leaving DATA is decided there.
          if (count_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_q <= par_en_q ? ST_PARITY : ST_STOP;
`else
            state_q <= ST_STOP;
`endif
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        ST_PARITY: begin
          state_q <= ST_STOP;
        end
        ST_STOP: begin
          state_q <= data_valid ? ST_START : ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mux_sel  = MUX_STOP;
    busy     = 1'b1;
    ser_data = data_q[0];
    case (state_q)
      ST_IDLE:   busy = 1'b0;
      ST_START:  mux_sel = MUX_START;
      ST_DATA: begin
        mux_sel  = MUX_DATA;
        ser_data = data_q[count_q];
      end
      ST_PARITY: mux_sel = MUX_PARITY;
      ST_STOP:   mux_sel = MUX_STOP;
      default:   busy = 1'b0;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  uart_tx_parity #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data    (data_q),
    .par_typ (par_typ_q),
    .par_bit (par_bit)
  );
`else
  assign par_bit = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl -- scoreboard bench for uart_tx_ctrl. The driver builds each
// expected frame from the framing rules and queues one record per clock cycle;
// a monitor on the falling edge pops and compares every record.
module tb_uart_tx_ctrl;
  import uart_tx_pkg::*;

  localparam int unsigned DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_en;
  logic          par_typ;
  logic [1:0]    mux_sel;
  logic          ser_data;
  logic          par_bit;
  logic          busy;

  always #5 clk = ~clk;

  uart_tx_ctrl #(
    .DATA_WIDTH(DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .busy       (busy)
  );

  typedef struct {
    logic [1:0] mux;
    logic       bsy;
    logic       ser;
    logic       par;
    int         tag;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] last_data;
  logic          last_par;

  function automatic logic model_par(input logic [DW-1:0] d, input logic pt);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DW; i++) r = r ^ d[i];
    return HAS_PAR ? (r ^ pt) : 1'b0;
  endfunction

  task automatic push(input logic [1:0] m, input logic b, input logic s,
                      input logic p, input int tag);
    exp_t e;
    e.mux = m; e.bsy = b; e.ser = s; e.par = p; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic advance();
    @(negedge clk);
    #1;
  endtask

  // Inputs that must be ignored while a frame is in flight.
  task automatic junk(input logic [DW-1:0] d, input logic pe, input logic pt);
    data_valid = 1'($urandom);
    p_data     = ~d;
    par_en     = ~pe;
    par_typ    = ~pt;
  endtask

  task automatic do_abort(input int tag);
    rst = 1'b0;
    #1;
    tests++;
    if ({mux_sel, busy, ser_data, par_bit} !== {MUX_STOP, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset tag=%0d: got mux=%b busy=%b ser=%b par=%b, expected mux=11 busy=0 ser=0 par=0",
               tag, mux_sel, busy, ser_data, par_bit);
    end
    last_data  = '0;
    last_par   = 1'b0;
    data_valid = 1'b0;
    push(MUX_STOP, 1'b0, 1'b0, 1'b0, tag);
    advance();
    rst = 1'b1;
    push(MUX_STOP, 1'b0, 1'b0, 1'b0, tag);
    advance();
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input int gap, input int tag, input int abort_bit);
    logic fp;
    fp = model_par(d, pt);
    for (int g = 0; g < gap; g++) begin
      data_valid = 1'b0;
      p_data     = DW'($urandom);
      par_en     = 1'($urandom);
      par_typ    = 1'($urandom);
      push(MUX_STOP, 1'b0, last_data[0], last_par, tag);
      advance();
    end
    data_valid = 1'b1;
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    last_data  = d;
    last_par   = fp;
    push(MUX_START, 1'b1, d[0], fp, tag);
    advance();
    for (int i = 0; i < DW; i++) begin
      junk(d, pe, pt);
      push(MUX_DATA, 1'b1, d[i], fp, tag);
      advance();
      if (i == abort_bit) begin
        do_abort(tag);
        return;
      end
    end
    if (HAS_PAR && pe) begin
      junk(d, pe, pt);
      push(MUX_PARITY, 1'b1, d[0], fp, tag);
      advance();
    end
    junk(d, pe, pt);
    push(MUX_STOP, 1'b1, d[0], fp, tag);
    advance();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      tests++;
      if ({mux_sel, busy, ser_data, par_bit} !== {mon_e.mux, mon_e.bsy, mon_e.ser, mon_e.par}) begin
        fails++;
        $display("FAIL frame_cycle tag=%0d t=%0t: got mux=%b busy=%b ser=%b par=%b, expected mux=%b busy=%b ser=%b par=%b",
                 mon_e.tag, $time, mux_sel, busy, ser_data, par_bit,
                 mon_e.mux, mon_e.bsy, mon_e.ser, mon_e.par);
      end
    end
  end

  initial begin
    rst        = 1'b0;
    data_valid = 1'b0;
    p_data     = '0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    last_data  = '0;
    last_par   = 1'b0;

    // Reset state, checked before and across the first edge.
    #2;
    tests++;
    if ({mux_sel, busy, ser_data, par_bit} !== {MUX_STOP, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got mux=%b busy=%b ser=%b par=%b, expected mux=11 busy=0 ser=0 par=0",
               mux_sel, busy, ser_data, par_bit);
    end
    push(MUX_STOP, 1'b0, 1'b0, 1'b0, 0);
    advance();
    rst = 1'b1;
    push(MUX_STOP, 1'b0, 1'b0, 1'b0, 0);
    advance();

    // Directed frames.
    send_frame(8'hA5, 1'b0, 1'b0, 1, 1, -1);
    send_frame(8'hA5, 1'b1, 1'b0, 1, 2, -1);
    send_frame(8'hA5, 1'b1, 1'b1, 2, 3, -1);
    send_frame(8'h3C, 1'b0, 1'b0, 1, 4, -1);
    send_frame(8'hC3, 1'b0, 1'b0, 0, 5, -1);
    send_frame(8'h0F, 1'b0, 1'b0, 1, 6, -1);
    send_frame(8'h5A, 1'b1, 1'b1, 1, 7, 3);
    send_frame(8'h96, 1'b1, 1'b0, 0, 8, -1);
    send_frame(8'h01, 1'b1, 1'b1, 0, 9, -1);

    // Randomized frames with random inter-frame gaps (0 = back-to-back).
    for (int n = 0; n < 40; n++) begin
      send_frame(DW'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 2)), 100 + n, -1);
    end

    for (int k = 0; k < 3; k++) begin
      data_valid = 1'b0;
      push(MUX_STOP, 1'b0, last_data[0], last_par, 999);
      advance();
    end

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending records, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the number of payload bits per frame.
REQ-002 The block SHALL have port clk, input, 1 bit: the single bit-rate clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port p_data, input, DATA_WIDTH bits: the parallel payload.
REQ-005 The block SHALL have port data_valid, input, 1 bit: p_data is offered for transmission.
REQ-006 The block SHALL have port par_en, input, 1 bit: a parity bit is appended to the frame.
REQ-007 The block SHALL have port par_typ, input, 1 bit: 0 selects even parity, 1 selects odd parity.
REQ-008 The block SHALL have port mux_sel, output, 2 bits: the line-source select (00 start, 01 data, 10 parity, 11 stop/idle).
REQ-009 The block SHALL have port ser_data, output, 1 bit: the current payload bit.
REQ-010 The block SHALL have port par_bit, output, 1 bit: the computed parity bit.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.

Function
REQ-012 The FSM SHALL use states IDLE, START, DATA, PARITY and STOP, each lasting one clk cycle, except DATA, which lasts DATA_WIDTH cycles.
REQ-013 The outputs SHALL decode from state: IDLE/STOP give mux_sel=11; START gives 00; DATA gives 01; PARITY gives 10.
REQ-014 busy SHALL be 0 in IDLE and 1 in START, DATA, PARITY and STOP.
REQ-015 In IDLE with data_valid=1 at a rising edge, the block SHALL latch p_data, par_en and par_typ, and enter START on that edge.
REQ-016 data_valid, p_data, par_en and par_typ SHALL be ignored in START, DATA and PARITY; changes to them SHALL NOT affect the frame in flight.
REQ-017 The transition rules SHALL be: START->DATA; DATA->PARITY after bit DATA_WIDTH-1 when the latched par_en=1, otherwise DATA->STOP; PARITY->STOP.
REQ-018 In STOP, data_valid=1 SHALL latch new inputs and go directly to START, with no idle cycle; otherwise the FSM SHALL go to IDLE.
REQ-019 A bit counter of width clog2(DATA_WIDTH) SHALL drive ser_data = latched_data[count], LSB first, and clear on entry to DATA.
REQ-020 The counter SHALL stop at DATA_WIDTH-1 and SHALL never wrap inside a frame.
REQ-021 par_bit SHALL equal the XOR-reduction of the latched data, XOR the latched par_typ, and SHALL be stable for the whole frame.
REQ-022 ser_data SHALL equal latched_data[0] outside DATA.
REQ-023 The frame length SHALL be 2+DATA_WIDTH+latched par_en cycles.

Reset
REQ-024 Asserting rst low at any time, including mid-frame, SHALL force IDLE immediately, with no completion of the current frame.
REQ-025 Under reset: mux_sel=11, busy=0, counter=0, latched data=0, ser_data=0, par_bit=0.
REQ-026 After rst deasserts, the first data_valid SHALL start a normal frame.

Configuration
REQ-027 With macro UART_TX_PARITY_EN defined, the PARITY state and parity logic SHALL be present as specified.
REQ-028 Without UART_TX_PARITY_EN, par_en and par_typ SHALL be ignored, PARITY SHALL never be entered, par_bit SHALL tie to 0, and the frame length SHALL be 2+DATA_WIDTH cycles.

Structure
REQ-029 Package uart_tx_pkg SHALL hold the state enum and the mux_sel encodings MUX_START=00, MUX_DATA=01, MUX_PARITY=10, MUX_STOP=11.
REQ-030 Parity computation SHALL be a sub-module uart_tx_parity (inputs data and par_typ; output par_bit), instantiated only under UART_TX_PARITY_EN.

Verification
REQ-031 p_data=0xA5, par_en=0, one data_valid pulse -> mux_sel 00, eight cycles of 01 with ser_data 1,0,1,0,0,1,0,1, then 11; busy high for 10 cycles.
REQ-032 p_data=0xA5, par_en=1, par_typ=0 -> 11-cycle frame; the PARITY cycle has mux_sel=10 and par_bit=0; with par_typ=1, par_bit=1.
REQ-033 data_valid held high with p_data=0x3C, then 0xC3 -> the second START immediately follows the first STOP, with no IDLE cycle between frames.
REQ-034 p_data changed from 0x0F to 0xF0 mid-DATA -> the serialized bits remain 1,1,1,1,0,0,0,0.
REQ-035 rst pulsed low during DATA bit 3 -> mux_sel=11 and busy=0 immediately; the next data_valid produces a full, correct frame.
REQ-036 Build without UART_TX_PARITY_EN, par_en=1 -> 10-cycle frame, mux_sel never 10.
